paddle_centroid: RTL and testbench
==================================

// Module: paddle_centroid
// PURPOSE
//  Consumes the per-pixel 2-bit colour mask from two_color_mask and localizes both paddles once per frame.
//  Per colour it accumulates pixel count and row/col sums over the frame.
//  At frame end it runs a serial divider to produce integer centroids (x,y) and a found flag.
//  Results feed the game/overlay logic. Pixels arrive in raster order: col fastest, then row.
// PARAMETERS
//  WIDTH      640  active pixels per line
//  HEIGHT     480  active lines per frame
//  COORD_W    10   width of col/row coordinates and centroid outputs
//  CNT_W      19   width of per-colour pixel count (>= clog2(WIDTH*HEIGHT+1))
//  SUM_W      28   width of per-colour coordinate sums (>= CNT_W+COORD_W-1)
//  MIN_COUNT  64   minimum pixel count for a colour to be reported found
// PORTS
//  clk            in   1        pixel clock
//  reset_n        in   1        async active-low reset
//  frame_start    in   1        sync pulse; resynchronizes raster counters to (0,0)
//  in_valid       in   1        mask pixel valid (two_color_mask out_valid)
//  colorEncoding  in   2        [1]=colour1 hit, [0]=colour2 hit
//  c1_found       out  1        colour1 count >= MIN_COUNT in last completed frame
//  c1_x, c1_y     out  COORD_W  colour1 centroid col,row (floor of sum/count)
//  c1_count       out  CNT_W    colour1 pixel count of last completed frame
//  c2_found       out  1        same, colour2
//  c2_x, c2_y     out  COORD_W  same, colour2
//  c2_count       out  CNT_W    same, colour2
//  result_valid   out  1        1-cycle pulse: all c1_*/c2_* outputs updated this cycle
//  busy           out  1        divider running
//  frame_overrun  out  1        1-cycle pulse: frame ended while busy; that frame is dropped
// BEHAVIOUR
//  Reset: all outputs, accumulators, raster counters 0; FSM to S_IDLE. Reset mid-division aborts it, no result_valid.
//  Raster counters col/row advance only on in_valid. col wraps WIDTH-1->0 and then row++; row wraps HEIGHT-1->0.
//  frame_start: col,row,accumulators clear. If in_valid is high in the same cycle, that pixel is taken as (0,0) and accumulated.
//  Accumulate on in_valid: for each set bit, cnt+=1, sumx+=col, sumy+=row. Both bits set -> both colours update.
//  Last pixel: in_valid at (WIDTH-1,HEIGHT-1).
//   - That pixel is included in the snapshot.
//   - cnt/sums copy to snapshot registers; live accumulators clear on the same edge, so the next frame starts clean with no gap cycle.
//   - If the FSM is not S_IDLE, the snapshot is discarded, frame_overrun pulses, and the running division continues unaffected.
//  FSM:
//   - S_IDLE: last pixel -> S_LOAD, div_sel=0.
//   - S_LOAD (1 cycle): load dividend=sum[div_sel], divisor=cnt[colour], rem=0 -> S_DIV.
//   - S_DIV (SUM_W cycles): restoring division, one quotient bit per cycle, MSB first.
//     After the last bit: if div_sel<3, div_sel++ and go to S_LOAD; otherwise go to S_DONE.
//   - S_DONE (1 cycle): update outputs, pulse result_valid -> S_IDLE.
//   - div_sel order: 0=c1x, 1=c1y, 2=c2x, 3=c2y.
//  Latency: result_valid is high exactly 4*(SUM_W+1)+1 cycles after the last-pixel edge (117 at defaults).
//  busy=1 in S_LOAD, S_DIV and S_DONE.
//  Divide-by-zero or count<MIN_COUNT: that colour reports found=0, x=y=0, count=true count. The division still runs, so timing is fixed.
//  Quotient is truncated to COORD_W LSBs; it is always <= WIDTH-1 by construction.
//  Outputs hold their values between result_valid pulses.
// TESTING
//  1. Frame with no hits -> after 117 cycles result_valid=1, both found=0, x=y=count=0.
//  2. Colour1 = 10x10 block cols 100-109, rows 50-59 -> c1_count=100, c1_x=104, c1_y=54, c1_found=1, c2_found=0.
//  3. Every pixel encoded 2'b11 -> both count=307200, x=319, y=239, found=1.
//  4. 63 colour2 pixels -> c2_found=0, c2_count=63. 64 pixels -> c2_found=1.
//  5. Second frame end forced 50 cycles after first -> frame_overrun pulse; next result_valid reflects the first frame only.
//  6. frame_start mid-frame, then a full frame -> results cover only post-sync pixels. Reset during S_DIV -> no result_valid, outputs 0.

Source files
------------

// File: rtl/paddle_centroid.sv
// rtl/paddle_centroid.sv - per-frame two-colour pixel accumulator with serial centroid divider
module paddle_centroid #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int COORD_W   = 10,
    parameter int CNT_W     = 19,
    parameter int SUM_W     = 28,
    parameter int MIN_COUNT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               in_valid,
    input  logic [1:0]         colorEncoding,
    output logic               c1_found,
    output logic [COORD_W-1:0] c1_x,
    output logic [COORD_W-1:0] c1_y,
    output logic [CNT_W-1:0]   c1_count,
    output logic               c2_found,
    output logic [COORD_W-1:0] c2_x,
    output logic [COORD_W-1:0] c2_y,
    output logic [CNT_W-1:0]   c2_count,
    output logic               result_valid,
    output logic               busy,
    output logic               frame_overrun
);
    localparam int BW = $clog2(SUM_W);
    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]   MIN_C   = CNT_W'(MIN_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;
    state_t state, state_nxt;

    logic [COORD_W-1:0] col, row, eff_col, eff_row;
    logic               last_pix;
    logic [1:0]         hit;
    logic [CNT_W-1:0]   cnt [2];
    logic [CNT_W-1:0]   cnt_nxt [2];
    logic [CNT_W-1:0]   snap_cnt [2];
    logic [SUM_W-1:0]   sx [2];
    logic [SUM_W-1:0]   sy [2];
    logic [SUM_W-1:0]   sx_nxt [2];
    logic [SUM_W-1:0]   sy_nxt [2];
    logic [SUM_W-1:0]   snap_sx [2];
    logic [SUM_W-1:0]   snap_sy [2];
    logic [COORD_W-1:0] quo [4];

    logic [SUM_W-1:0]   dvd;
    logic [CNT_W-1:0]   dvs, rem;
    logic [CNT_W:0]     trial;
    logic               qbit, last_bit;
    logic [BW-1:0]      bit_cnt;
    logic [1:0]         div_sel;
    logic               found1, found2;

    // frame_start forces the coincident pixel to (0,0) and drops the old partial frame
    always_comb begin
        eff_col  = frame_start ? '0 : col;
        eff_row  = frame_start ? '0 : row;
        last_pix = in_valid && (eff_col == COL_MAX) && (eff_row == ROW_MAX);
        hit      = {in_valid & colorEncoding[0], in_valid & colorEncoding[1]};
        for (int k = 0; k < 2; k++) begin
            cnt_nxt[k] = (frame_start ? '0 : cnt[k]) + CNT_W'(hit[k]);
            sx_nxt[k]  = (frame_start ? '0 : sx[k]) + (hit[k] ? SUM_W'(eff_col) : '0);
            sy_nxt[k]  = (frame_start ? '0 : sy[k]) + (hit[k] ? SUM_W'(eff_row) : '0);
        end
    end

    always_comb begin
        trial    = {rem, dvd[SUM_W-1]};
        qbit     = (trial >= {1'b0, dvs});
        last_bit = (bit_cnt == BW'(SUM_W - 1));
        found1   = (snap_cnt[0] >= MIN_C) && (snap_cnt[0] != '0);
        found2   = (snap_cnt[1] >= MIN_C) && (snap_cnt[1] != '0);
        busy     = (state != S_IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (last_pix) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DIV;
            S_DIV:   if (last_bit) state_nxt = (div_sel == 2'd3) ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;  sx[k] <= '0;  sy[k] <= '0;
                snap_cnt[k] <= '0;  snap_sx[k] <= '0;  snap_sy[k] <= '0;
            end
            for (int j = 0; j < 4; j++) quo[j] <= '0;
            dvd <= '0;  dvs <= '0;  rem <= '0;  bit_cnt <= '0;  div_sel <= '0;
            c1_found <= 1'b0;  c1_x <= '0;  c1_y <= '0;  c1_count <= '0;
            c2_found <= 1'b0;  c2_x <= '0;  c2_y <= '0;  c2_count <= '0;
            result_valid  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            result_valid  <= 1'b0;
            frame_overrun <= last_pix && (state != S_IDLE);

            if (in_valid) begin
                if (eff_col == COL_MAX) begin
                    col <= '0;
                    row <= (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end

            for (int k = 0; k < 2; k++) begin
                cnt[k] <= last_pix ? '0 : cnt_nxt[k];
                sx[k]  <= last_pix ? '0 : sx_nxt[k];
                sy[k]  <= last_pix ? '0 : sy_nxt[k];
                if (last_pix && (state == S_IDLE)) begin
                    snap_cnt[k] <= cnt_nxt[k];
                    snap_sx[k]  <= sx_nxt[k];
                    snap_sy[k]  <= sy_nxt[k];
                end
            end

            case (state)
                S_IDLE: if (last_pix) div_sel <= 2'd0;
                S_LOAD: begin
                    case (div_sel)
                        2'd0:    dvd <= snap_sx[0];
                        2'd1:    dvd <= snap_sy[0];
                        2'd2:    dvd <= snap_sx[1];
                        default: dvd <= snap_sy[1];
                    endcase
                    dvs     <= snap_cnt[div_sel[1]];
                    rem     <= '0;
                    bit_cnt <= '0;
                end
                S_DIV: begin
                    // restoring step; the dividend register fills with quotient bits from the LSB
                    rem     <= qbit ? CNT_W'(trial - {1'b0, dvs}) : trial[CNT_W-1:0];
                    dvd     <= {dvd[SUM_W-2:0], qbit};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        quo[div_sel] <= {dvd[COORD_W-2:0], qbit};
                        if (div_sel != 2'd3) div_sel <= div_sel + 1'b1;
                    end
                end
                S_DONE: begin
                    c1_found <= found1;
                    c1_x     <= found1 ? quo[0] : '0;
                    c1_y     <= found1 ? quo[1] : '0;
                    c1_count <= snap_cnt[0];
                    c2_found <= found2;
                    c2_x     <= found2 ? quo[2] : '0;
                    c2_y     <= found2 ? quo[3] : '0;
                    c2_count <= snap_cnt[1];
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_paddle_centroid.sv
// tb/tb_paddle_centroid.sv - scoreboard bench for paddle_centroid on a reduced 8x6 raster
module tb_paddle_centroid;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int CW   = 10;
    localparam int NW   = 19;
    localparam int SW   = 28;
    localparam int MINC = 16;
    localparam int LAT  = 4 * (SW + 1) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frame_start, in_valid;
    logic [1:0]    colorEncoding;
    logic          c1_found, c2_found, result_valid, busy, frame_overrun;
    logic [CW-1:0] c1_x, c1_y, c2_x, c2_y;
    logic [NW-1:0] c1_count, c2_count;

    paddle_centroid #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CNT_W(NW), .SUM_W(SW), .MIN_COUNT(MINC)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .in_valid(in_valid),
        .colorEncoding(colorEncoding),
        .c1_found(c1_found), .c1_x(c1_x), .c1_y(c1_y), .c1_count(c1_count),
        .c2_found(c2_found), .c2_x(c2_x), .c2_y(c2_y), .c2_count(c2_count),
        .result_valid(result_valid), .busy(busy), .frame_overrun(frame_overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          f1, f2;
        logic [CW-1:0] x1, y1, x2, y2;
        logic [NW-1:0] n1, n2;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [1:0] mask [H][W];
    int tests = 0, fails = 0;
    int cyc = 0, last_t = 0, ovr_cnt = 0, rv_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every result_valid pops the oldest expected frame
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_overrun) ovr_cnt++;
            if (result_valid) begin
                rv_cnt++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: result_valid=1 required no result");
                end else begin
                    e = sb.pop_front();
                    tests += 8;
                    if (c1_found !== e.f1) begin fails++; $display("FAIL c1_found: got %0b want %0b", c1_found, e.f1); end
                    if (c1_x !== e.x1) begin fails++; $display("FAIL c1_x: got %0d want %0d", c1_x, e.x1); end
                    if (c1_y !== e.y1) begin fails++; $display("FAIL c1_y: got %0d want %0d", c1_y, e.y1); end
                    if (c1_count !== e.n1) begin fails++; $display("FAIL c1_count: got %0d want %0d", c1_count, e.n1); end
                    if (c2_found !== e.f2) begin fails++; $display("FAIL c2_found: got %0b want %0b", c2_found, e.f2); end
                    if (c2_x !== e.x2) begin fails++; $display("FAIL c2_x: got %0d want %0d", c2_x, e.x2); end
                    if (c2_y !== e.y2) begin fails++; $display("FAIL c2_y: got %0d want %0d", c2_y, e.y2); end
                    if (c2_count !== e.n2) begin fails++; $display("FAIL c2_count: got %0d want %0d", c2_count, e.n2); end
                end
            end
        end
    end

    task automatic clear_mask();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mask[r][c] = 2'b00;
    endtask

    task automatic run_frame(input bit push, input bit gaps);
        exp_t   x;
        int     n [2];
        longint sx [2];
        longint sy [2];
        for (int k = 0; k < 2; k++) begin n[k] = 0; sx[k] = 0; sy[k] = 0; end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int k = 0; k < 2; k++)
                    if (mask[r][c][1-k]) begin n[k]++; sx[k] += c; sy[k] += r; end
        x.n1 = NW'(n[0]);
        x.n2 = NW'(n[1]);
        x.f1 = (n[0] >= MINC);
        x.f2 = (n[1] >= MINC);
        x.x1 = x.f1 ? CW'(sx[0] / n[0]) : '0;
        x.y1 = x.f1 ? CW'(sy[0] / n[0]) : '0;
        x.x2 = x.f2 ? CW'(sx[1] / n[1]) : '0;
        x.y2 = x.f2 ? CW'(sy[1] / n[1]) : '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0; frame_start = 1'b0; colorEncoding = 2'b11;
                end
                @(posedge clk); #1;
                in_valid      = 1'b1;
                frame_start   = (r == 0 && c == 0);
                colorEncoding = mask[r][c];
            end
        end
        @(posedge clk); #1;
        last_t        = cyc;
        in_valid      = 1'b0;
        frame_start   = 1'b0;
        colorEncoding = 2'b00;
        if (push) sb.push_back(x);
    endtask

    task automatic test_reset();
        tests += 2;
        if ({c1_found, c1_x, c1_y, c1_count, c2_found, c2_x, c2_y, c2_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got c1_count=%0d c1_x=%0d c2_count=%0d want all 0", c1_count, c1_x, c2_count);
        end
        if ({result_valid, busy, frame_overrun} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %03b want 000", {result_valid, busy, frame_overrun});
        end
    endtask

    task automatic test_no_hits();
        clear_mask();
        run_frame(1, 0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_last: got %0b want 1", busy); end
        for (int k = 0; k < 300 && result_valid !== 1'b1; k++) @(negedge clk);
        tests++;
        if (result_valid !== 1'b1 || cyc - last_t != LAT) begin
            fails++;
            $display("FAIL latency: got %0d cycles want %0d", cyc - last_t, LAT);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done: got %0b want 0", busy); end
    endtask

    task automatic test_block();
        clear_mask();
        for (int r = 1; r <= 4; r++)
            for (int c = 2; c <= 5; c++) mask[r][c] = 2'b10;
        for (int c = 0; c < 5; c++) mask[5][c] = 2'b01;
        run_frame(1, 1);
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL block_timeout: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_all_both();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mask[r][c] = 2'b11;
        run_frame(1, 0);
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL all_timeout: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_min_count();
        for (int n = MINC - 1; n <= MINC; n++) begin
            clear_mask();
            for (int i = 0; i < n; i++) mask[i / W][i % W] = 2'b01;
            run_frame(1, 0);
            for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
            tests++;
            if (sb.size() != 0 || c2_found !== (n >= MINC) || c2_count !== NW'(n)) begin
                fails++;
                $display("FAIL min_count_%0d: got found=%0b count=%0d want found=%0b count=%0d",
                         n, c2_found, c2_count, (n >= MINC), n);
            end
            sb.delete();
        end
    endtask

    task automatic test_overrun();
        int o0, r0;
        clear_mask();
        for (int r = 0; r < 3; r++)
            for (int c = 4; c < W; c++) mask[r][c] = 2'b10;
        for (int c = 0; c < W; c++) begin mask[4][c] = 2'b01; mask[5][c] = 2'b01; end
        o0 = ovr_cnt;
        r0 = rv_cnt;
        run_frame(1, 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mask[r][c] = 2'b11;
        run_frame(0, 0);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL overrun_busy: got %0b want 1", busy); end
        repeat (3) @(negedge clk);
        tests++;
        if (ovr_cnt != o0 + 1) begin fails++; $display("FAIL overrun_pulse: got %0d pulses want 1", ovr_cnt - o0); end
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        repeat (150) @(negedge clk);
        tests++;
        if (rv_cnt != r0 + 1) begin fails++; $display("FAIL overrun_results: got %0d want 1", rv_cnt - r0); end
        sb.delete();
    endtask

    task automatic test_resync();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; frame_start = 1'b0; colorEncoding = 2'b11;
        end
        clear_mask();
        mask[0][0] = 2'b01;
        for (int r = 2; r < H; r++)
            for (int c = 0; c < W; c++) mask[r][c] = (c < 4) ? 2'b01 : 2'b10;
        run_frame(1, 1);
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL resync_timeout: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_mid_div();
        int r0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mask[r][c] = 2'b11;
        run_frame(1, 0);
        repeat (60) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_div_busy: got %0b want 1", busy); end
        reset_n = 1'b0;
        @(negedge clk);
        sb.delete();
        tests++;
        if ({busy, c1_found, c1_count, c2_found, c2_count, c1_x, c2_y} !== '0) begin
            fails++;
            $display("FAIL mid_div_reset: got busy=%0b c1_count=%0d c2_count=%0d want 0", busy, c1_count, c2_count);
        end
        reset_n = 1'b1;
        r0 = rv_cnt;
        repeat (150) @(negedge clk);
        tests++;
        if (rv_cnt != r0 || c1_count !== '0) begin
            fails++;
            $display("FAIL mid_div_no_result: got %0d results c1_count=%0d want 0", rv_cnt - r0, c1_count);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        frame_start   = 1'b0;
        in_valid      = 1'b0;
        colorEncoding = 2'b00;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_no_hits();
        test_block();
        test_all_both();
        test_min_count();
        test_overrun();
        test_resync();
        test_reset_mid_div();
        tests++;
        if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
